// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment controller: sequential shift-add-3 binary to BCD
// over a load/busy handshake, digit scanning with leading-zero blanking and
// overflow dashes, plus a push-button debouncer with a one-cycle press pulse.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   value/value_load binary value and load request (taken only when idle)
//   lzb              leading-zero blanking enable (applied live)
//   button           raw push-button, active-high
//   busy             conversion in progress
//   btn_press        one-cycle pulse per debounced press
//   seg              segments g..a, active-low (registered)
//   an               digit enables, active-low one-hot (registered)
module seg7_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int VALUE_W      = 16,
    parameter int REFRESH_DIV  = 500000,
    parameter int DEBOUNCE_CYC = 650000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               value_load,
    input  logic               lzb,
    input  logic               button,
    output logic               busy,
    output logic               btn_press,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an
);

    localparam int BW  = 4 * DIGITS;
    localparam int SCW = $clog2(VALUE_W);
    localparam int RW  = $clog2(REFRESH_DIV);
    localparam int PW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0] MAX_DEC = pow10(DIGITS) - 32'd1;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ---------------- conversion FSM ----------------
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nx;
    logic [VALUE_W-1:0] sh, sh_nx;
    logic [BW-1:0]      bcd, bcd_nx, bcd_adj;
    logic [SCW-1:0]     step, step_nx;
    logic               ovf_pend, ovf_pend_nx;
    logic [BW-1:0]      disp, disp_nx;
    logic               disp_ovf, disp_ovf_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            bcd      <= '0;
            step     <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            disp_ovf <= 1'b0;
        end else begin
            state    <= state_nx;
            sh       <= sh_nx;
            bcd      <= bcd_nx;
            step     <= step_nx;
            ovf_pend <= ovf_pend_nx;
            disp     <= disp_nx;
            disp_ovf <= disp_ovf_nx;
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end

        state_nx    = state;
        sh_nx       = sh;
        bcd_nx      = bcd;
        step_nx     = step;
        ovf_pend_nx = ovf_pend;
        disp_nx     = disp;
        disp_ovf_nx = disp_ovf;

        case (state)
            IDLE: begin
                if (value_load) begin
                    sh_nx       = value;
                    bcd_nx      = '0;
                    step_nx     = '0;
                    ovf_pend_nx = (32'(value) > MAX_DEC);
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                sh_nx   = {sh[VALUE_W-2:0], 1'b0};
                // carries out of the top nibble are dropped; ovf covers them
                bcd_nx  = {bcd_adj[BW-2:0], sh[VALUE_W-1]};
                step_nx = step + 1'b1;
                // the last shift and the commit share one edge
                if (step == SCW'(VALUE_W - 1)) begin
                    disp_nx     = bcd_nx;
                    disp_ovf_nx = ovf_pend;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

    // ---------------- scan ----------------
    logic [RW-1:0] rcnt;
    logic [PW-1:0] p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            p    <= PW'(DIGITS - 1);
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            p    <= (p == '0) ? PW'(DIGITS - 1) : p - 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // hi_zero[i]: nibble i and every nibble above it are zero
    logic [DIGITS-1:0] hi_zero;
    logic              zacc;
    logic [3:0]        nib;
    logic              nib_hz;
    logic [6:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;

    always_comb begin
        hi_zero = '0;
        zacc    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zacc       = zacc & (disp[4*i +: 4] == 4'd0);
            hi_zero[i] = zacc;
        end

        nib    = 4'd0;
        nib_hz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (p == PW'(i)) begin
                nib    = disp[4*i +: 4];
                nib_hz = hi_zero[i];
            end
        end

        if (disp_ovf)
            seg_nx = SEG_DASH;
        else if (lzb && (p != '0) && nib_hz)
            seg_nx = SEG_BLANK;
        else
            seg_nx = dec7(nib);

        an_nx = ~(DIGITS'(1) << p);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_nx;
            an  <= an_nx;
        end
    end

    // ---------------- debounce ----------------
    logic          sync1, sync2, db;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db        <= 1'b0;
            dcnt      <= '0;
            btn_press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (sync2 != db) begin
                if (dcnt == DW'(DEBOUNCE_CYC)) begin
                    db        <= sync2;
                    dcnt      <= '0;
                    btn_press <= sync2;
                end else begin
                    dcnt      <= dcnt + 1'b1;
                    btn_press <= 1'b0;
                end
            end else begin
                dcnt      <= '0;
                btn_press <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_seg7_scan_ctrl;

    localparam int D  = 4;
    localparam int VW = 16;
    localparam int R  = 4;
    localparam int DB = 8;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZERO  = 7'b1000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [VW-1:0] value = '0;
    logic          value_load = 1'b0;
    logic          lzb = 1'b0;
    logic          button = 1'b0;
    logic          busy, btn_press;
    logic [6:0]    seg;
    logic [D-1:0]  an;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    seg7_scan_ctrl #(
        .DIGITS(D), .VALUE_W(VW), .REFRESH_DIV(R), .DEBOUNCE_CYC(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .value_load(value_load),
        .lzb(lzb), .button(button), .busy(busy), .btn_press(btn_press),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int unsigned p10(input int n);
        int unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int unsigned v, input bit o,
                                             input int pos, input logic lz);
        if (o) return DASH;
        if (lz && pos != 0 && v < p10(pos)) return BLANK;
        return glyph((v / p10(pos)) % 10);
    endfunction

    // leftmost position first, one position every R cycles
    function automatic int pos_of(input int unsigned e);
        return D - 1 - int'((e / R) % D);
    endfunction

    int unsigned   ecnt, disp_v, pend;
    bit            disp_o, db_m;
    int            busy_left;
    logic [DB+1:0] hist;
    logic [6:0]    exp_seg;
    logic [D-1:0]  exp_an;
    logic          exp_busy, exp_press;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt      <= 0;
            disp_v    <= 0;
            disp_o    <= 1'b0;
            pend      <= 0;
            busy_left <= 0;
            db_m      <= 1'b0;
            hist      <= '0;
            exp_seg   <= BLANK;
            exp_an    <= '1;
            exp_busy  <= 1'b0;
            exp_press <= 1'b0;
        end else begin
            ecnt    <= ecnt + 1;
            exp_an  <= ~(D'(1) << pos_of(ecnt));
            exp_seg <= model_seg(disp_v, disp_o, pos_of(ecnt), lzb);

            // level flips once DB+1 synchronised samples all disagree with it
            hist <= {hist[DB:0], button};
            if (hist[DB+1:1] == {(DB+1){~db_m}}) begin
                db_m      <= ~db_m;
                exp_press <= ~db_m;
            end else begin
                exp_press <= 1'b0;
            end

            if (busy_left == 0) begin
                if (value_load) begin
                    busy_left <= VW;
                    pend      <= int'(value);
                    exp_busy  <= 1'b1;
                end else begin
                    exp_busy <= 1'b0;
                end
            end else begin
                busy_left <= busy_left - 1;
                exp_busy  <= (busy_left > 1);
                if (busy_left == 1) begin
                    disp_v <= pend;
                    disp_o <= (pend > p10(D) - 1);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_seg", 32'(seg), 32'(exp_seg));
            check("m_an", 32'(an), 32'(exp_an));
            check("m_busy", 32'(busy), 32'(exp_busy));
            check("m_press", 32'(btn_press), 32'(exp_press));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit_digit(input string nm, input logic [D-1:0] pat,
                             input logic [6:0] want);
        bit found = 1'b0;
        for (int i = 0; i < 4 * R + 4 && !found; i++) begin
            @(negedge clk);
            if (an === pat) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: an %b never reached %b", nm, an, pat);
        end else begin
            check(nm, 32'(seg), 32'(want));
        end
    endtask

    task automatic run_load(input int v, input int inj, output int hi);
        value      = VW'(v);
        value_load = 1'b1;
        hi         = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) hi++;
            value_load = (i == inj);
            if (i == inj) value = VW'(1234);
        end
        value_load = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (busy === lvl) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy stuck at %b, wanted %b", nm, busy, lvl);
        end
    endtask

    task automatic count_press(input int n, output int c, output int first);
        c     = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (btn_press === 1'b1) begin
                c++;
                if (first < 0) first = i;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi, pc, c, fa;
        int vals[3];
        vals = '{9224, 9756, 9186};

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_seg", 32'(seg), 32'(BLANK));
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("first_an", 32'(an), 32'b0111);
        check("first_seg", 32'(seg), 32'(ZERO));

        tick(16);
        lit_digit("zero_p1", 4'b1101, ZERO);
        lzb = 1'b1;
        lit_digit("lzb0_p0", 4'b1110, ZERO);
        lit_digit("lzb0_p2", 4'b1011, BLANK);
        lzb = 1'b0;

        run_load(9625, -1, hi);
        check("busy_len", 32'(hi), 32'd16);
        lit_digit("d9625_p3", 4'b0111, 7'b0010000);
        lit_digit("d9625_p2", 4'b1011, 7'b0000010);
        lit_digit("d9625_p1", 4'b1101, 7'b0100100);
        lit_digit("d9625_p0", 4'b1110, 7'b0010010);

        run_load(9625, 5, hi);
        check("busy_len_ign", 32'(hi), 32'd16);
        lit_digit("ign_p3", 4'b0111, 7'b0010000);
        lit_digit("ign_p0", 4'b1110, 7'b0010010);

        value_load = 1'b1;
        foreach (vals[k]) begin
            value = VW'(vals[k]);
            wait_busy(1'b1, "b2b_start");
            wait_busy(1'b0, "b2b_end");
        end
        value_load = 1'b0;
        lit_digit("d9186_p3", 4'b0111, 7'b0010000);
        lit_digit("d9186_p0", 4'b1110, 7'b0000010);

        run_load(9999, -1, hi);
        lit_digit("d9999_p0", 4'b1110, 7'b0010000);
        run_load(10000, -1, hi);
        lit_digit("ovf_p0", 4'b1110, DASH);
        lit_digit("ovf_p3", 4'b0111, DASH);
        run_load(65535, -1, hi);
        lit_digit("max_p1", 4'b1101, DASH);
        lzb = 1'b1;
        run_load(0, -1, hi);
        lit_digit("z_lzb_p0", 4'b1110, ZERO);
        lit_digit("z_lzb_p3", 4'b0111, BLANK);
        run_load(7, -1, hi);
        lit_digit("s_lzb_p0", 4'b1110, 7'b1111000);
        lit_digit("s_lzb_p2", 4'b1011, BLANK);
        lzb = 1'b0;

        pc = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) button = ~button;
            @(negedge clk);
            if (btn_press === 1'b1) pc++;
        end
        button = 1'b0;
        count_press(3, c, fa);
        pc += c;
        check("bounce_none", 32'(pc), 32'd0);
        button = 1'b1;
        count_press(30, c, fa);
        check("press_cnt", 32'(c), 32'd1);
        check("press_lat", 32'(fa), 32'd11);
        button = 1'b0;
        count_press(20, c, fa);
        check("release_none", 32'(c), 32'd0);

        button = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        #2 rst_n = 1'b1;
        count_press(30, c, fa);
        check("held_cnt", 32'(c), 32'd1);
        check("held_lat", 32'(fa), 32'd11);
        button = 1'b0;
        tick(20);

        value      = VW'(4321);
        value_load = 1'b1;
        @(negedge clk);
        value_load = 1'b0;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seg", 32'(seg), 32'(BLANK));
        check("abort_an", 32'(an), 32'hF);
        @(negedge clk);
        #2 rst_n = 1'b1;
        lit_digit("abort_p3", 4'b0111, ZERO);
        lit_digit("abort_p0", 4'b1110, ZERO);

        for (int i = 0; i < 600; i++) begin
            value_load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1)
                value = VW'($urandom_range(0, 9999));
            else
                value = VW'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0) lzb = ~lzb;
            if ($urandom_range(0, 5) == 0) button = ~button;
            @(negedge clk);
        end
        value_load = 1'b0;
        tick(40);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
